// File: rtl/rf_pkg.sv
// Shared register-file definitions: window/register geometry and the
// window-relative to physical register index mapping. Both the writeback
// queue and the register file use this package, so they agree on aliasing.
//   NUM_WINDOWS   - architectural register windows (4)
//   NUM_PHYS_REGS - physical registers backing all windows (8)
//   phys_idx()    - (2*win + reg) mod 8; adjacent windows overlap by 2 regs
package rf_pkg;

  localparam int NUM_WINDOWS   = 4;
  localparam int NUM_PHYS_REGS = 8;
  localparam int WIN_W         = 2;
  localparam int REG_W         = 2;
  localparam int PHYS_W        = 3;

  typedef logic [WIN_W-1:0]  win_t;
  typedef logic [REG_W-1:0]  reg_t;
  typedef logic [PHYS_W-1:0] phys_t;

  // Windows step by two physical registers, so the top half of window w
  // is the bottom half of window w+1; the wrap past 7 is the mod 8.
  function automatic phys_t phys_idx(input win_t win, input reg_t rnum);
    logic [3:0] sum;
    sum = {1'b0, win, 1'b0} + {2'b00, rnum};
    return sum[PHYS_W-1:0];
  endfunction

endpackage

// File: rtl/wbq_fifo.sv
// Circular buffer holding pending register writebacks.
//   clk, rst_n         - clock, asynchronous active-low reset
//   push, pop, flush   - enqueue at tail / dequeue head / discard everything
//   push_win/reg/data  - entry written on push
//   count              - current occupancy (0..DEPTH)
//   rd_ptr             - head slot index
//   ent_win/reg/data   - raw slot contents, exposed for head readout and
//                        forwarding lookup in the parent
// The parent only pushes when count < DEPTH and only pops when count != 0.
module wbq_fifo
  import rf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           push,
  input  logic                           pop,
  input  logic                           flush,
  input  win_t                           push_win,
  input  reg_t                           push_reg,
  input  logic [DW-1:0]                  push_data,
  output logic [$clog2(DEPTH):0]         count,
  output logic [$clog2(DEPTH)-1:0]       rd_ptr,
  output win_t [DEPTH-1:0]               ent_win,
  output reg_t [DEPTH-1:0]               ent_reg,
  output logic [DEPTH-1:0][DW-1:0]       ent_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] wr_ptr;

  // DEPTH is a power of two, so pointer increment wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      ent_win  <= '0;
      ent_reg  <= '0;
      ent_data <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        ent_win[wr_ptr]  <= push_win;
        ent_reg[wr_ptr]  <= push_reg;
        ent_data[wr_ptr] <= push_data;
        wr_ptr           <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: rtl/reg_writeback_queue.sv
// Queue of pending register-file writebacks with store-to-load forwarding.
//   clk, rst_n                 - clock, asynchronous active-low reset
//   wb_valid/wb_ready          - request handshake
//   wb_win, wb_reg, wb_data    - request address (window-relative) and value
//   drain_en                   - register-file write port granted this cycle
//   flush                      - discard all queued entries at this edge
//   rf_we, rf_win/reg/wdata    - head entry presented to the register file
//   lk_win, lk_reg             - forwarding lookup address
//   lk_hit, lk_data            - newest queued value for that physical reg
//   count                      - occupancy
//
// Handshakes: a request transfers on a rising edge where wb_valid and
// wb_ready are both 1 (and flush is 0); wb_ready depends only on occupancy,
// never on wb_valid or drain_en, and wb_* need not be held when wb_ready is 0.
// The head transfers to the register file on every edge where rf_we is 1;
// the register file captures rf_win/rf_reg/rf_wdata on that same edge.
module reg_writeback_queue
  import rf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wb_valid,
  output logic                   wb_ready,
  input  logic [1:0]             wb_win,
  input  logic [1:0]             wb_reg,
  input  logic [DW-1:0]          wb_data,
  input  logic                   drain_en,
  input  logic                   flush,
  output logic                   rf_we,
  output logic [1:0]             rf_win,
  output logic [1:0]             rf_reg,
  output logic [DW-1:0]          rf_wdata,
  input  logic [1:0]             lk_win,
  input  logic [1:0]             lk_reg,
  output logic                   lk_hit,
  output logic [DW-1:0]          lk_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic                     push;
  logic [PW-1:0]            rd_ptr;
  win_t [DEPTH-1:0]         ent_win;
  reg_t [DEPTH-1:0]         ent_reg;
  logic [DEPTH-1:0][DW-1:0] ent_data;
  logic                     not_empty;

  assign not_empty = (count != '0);
  assign wb_ready  = (count < CW'(DEPTH));
  assign push      = wb_valid && wb_ready && !flush;
  assign rf_we     = not_empty && drain_en && !flush;

  wbq_fifo #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (rf_we),
    .flush     (flush),
    .push_win  (wb_win),
    .push_reg  (wb_reg),
    .push_data (wb_data),
    .count     (count),
    .rd_ptr    (rd_ptr),
    .ent_win   (ent_win),
    .ent_reg   (ent_reg),
    .ent_data  (ent_data)
  );

  // Head readout is forced to zero when empty so stale slots never show.
  assign rf_win   = not_empty ? ent_win[rd_ptr]  : '0;
  assign rf_reg   = not_empty ? ent_reg[rd_ptr]  : '0;
  assign rf_wdata = not_empty ? ent_data[rd_ptr] : '0;

  // Walk slots oldest to newest; a later match overrides an earlier one,
  // so the result is the newest resident write to that physical register.
  // Only stored entries are scanned, so same-cycle wb_data is not forwarded.
  phys_t         lk_phys;
  logic [PW-1:0] slot;

  always_comb begin
    lk_hit  = 1'b0;
    lk_data = '0;
    slot    = '0;
    lk_phys = phys_idx(lk_win, lk_reg);
    for (int k = 0; k < DEPTH; k++) begin
      slot = rd_ptr + PW'(k);
      if ((CW'(k) < count) && (phys_idx(ent_win[slot], ent_reg[slot]) == lk_phys)) begin
        lk_hit  = 1'b1;
        lk_data = ent_data[slot];
      end
    end
  end

endmodule

// File: tb/tb_reg_writeback_queue.sv
module tb_reg_writeback_queue;

  localparam int DEPTH = 4;
  localparam int DW    = 16;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int W     = 4 + DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          wb_valid, wb_ready, drain_en, flush, rf_we, lk_hit;
  logic [1:0]    wb_win, wb_reg, rf_win, rf_reg, lk_win, lk_reg;
  logic [DW-1:0] wb_data, rf_wdata, lk_data;
  logic [CW-1:0] count;

  reg_writeback_queue #(.DEPTH(DEPTH), .DW(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wb_valid (wb_valid),
    .wb_ready (wb_ready),
    .wb_win   (wb_win),
    .wb_reg   (wb_reg),
    .wb_data  (wb_data),
    .drain_en (drain_en),
    .flush    (flush),
    .rf_we    (rf_we),
    .rf_win   (rf_win),
    .rf_reg   (rf_reg),
    .rf_wdata (rf_wdata),
    .lk_win   (lk_win),
    .lk_reg   (lk_reg),
    .lk_hit   (lk_hit),
    .lk_data  (lk_data),
    .count    (count)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;
  int vectors     = 0;
  int miscompares = 0;
  int m_count     = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every register-file write must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && rf_we) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL rf_write: got win=%0d reg=%0d data=%h, expected no write (t=%0t)",
                 rf_win, rf_reg, rf_wdata, $time);
      end else begin
        mon_e = exp_q.pop_front();
        if ({rf_win, rf_reg, rf_wdata} !== mon_e) begin
          miscompares++;
          $display("FAIL rf_write: got win=%0d reg=%0d data=%h, expected win=%0d reg=%0d data=%h (t=%0t)",
                   rf_win, rf_reg, rf_wdata, mon_e[W-1:W-2], mon_e[W-3:W-4], mon_e[DW-1:0], $time);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; drives one cycle, checks the
  // handshake outputs mid-cycle, then advances the occupancy model.
  task automatic step(input logic v, input logic [1:0] w, input logic [1:0] r,
                      input logic [DW-1:0] d, input logic dr, input logic fl);
    logic acc, pop;
    wb_valid = v; wb_win = w; wb_reg = r; wb_data = d;
    drain_en = dr; flush = fl;
    acc = v && (m_count < DEPTH) && !fl;
    pop = (m_count != 0) && dr && !fl;
    @(negedge clk);
    chk("wb_ready", wb_ready, (m_count < DEPTH));
    chk("rf_we", rf_we, pop);
    chk("count", count, m_count);
    @(posedge clk); #1;
    if (fl) begin
      exp_q.delete();
      m_count = 0;
    end else begin
      m_count = m_count + int'(acc) - int'(pop);
      if (acc) exp_q.push_back({w, r, d});
    end
    wb_valid = 1'b0; drain_en = 1'b0; flush = 1'b0;
  endtask

  task automatic push_nd(input logic [1:0] w, input logic [1:0] r, input logic [DW-1:0] d);
    step(1'b1, w, r, d, 1'b0, 1'b0);
  endtask

  task automatic drain_all();
    for (int i = 0; i < 16 && m_count != 0; i++) step(1'b0, 2'd0, 2'd0, '0, 1'b1, 1'b0);
  endtask

  task automatic chk_lk(input logic [1:0] w, input logic [1:0] r,
                        input logic hit, input logic [DW-1:0] d);
    lk_win = w; lk_reg = r;
    #1;
    chk("lk_hit", lk_hit, hit);
    chk("lk_data", lk_data, d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200us");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    wb_valid = 1'b1; wb_win = 2'd1; wb_reg = 2'd1; wb_data = 16'hFFFF;
    drain_en = 1'b1; flush = 1'b0; lk_win = 2'd1; lk_reg = 2'd1;

    // Reset values, with requests held active during reset.
    @(posedge clk); #2;
    chk("rst_count", count, 0);
    chk("rst_wb_ready", wb_ready, 1);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_lk_hit", lk_hit, 0);
    chk("rst_rf_wdata", rf_wdata, 0);
    chk("rst_lk_data", lk_data, 0);
    wb_valid = 1'b0; drain_en = 1'b0;
    @(negedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Single push then drain: one-cycle latency.
    step(1'b1, 2'd1, 2'd2, 16'h00AA, 1'b1, 1'b0);
    fork
      step(1'b0, 2'd0, 2'd0, '0, 1'b1, 1'b0);
      begin
        @(negedge clk); #1;
        chk("t1_rf_win", rf_win, 1);
        chk("t1_rf_reg", rf_reg, 2);
        chk("t1_rf_wdata", rf_wdata, 16'h00AA);
      end
    join
    step(1'b0, 2'd0, 2'd0, '0, 1'b0, 1'b0);

    // Fill to DEPTH, fifth push ignored, drain in order.
    push_nd(2'd0, 2'd0, 16'hA001);
    push_nd(2'd1, 2'd1, 16'hA002);
    push_nd(2'd2, 2'd2, 16'hA003);
    push_nd(2'd3, 2'd3, 16'hA004);
    push_nd(2'd3, 2'd0, 16'hDEAD);
    drain_all();
    step(1'b0, 2'd0, 2'd0, '0, 1'b0, 1'b0);

    // Aliasing lookup, newest wins, same-cycle data not forwarded.
    push_nd(2'd0, 2'd2, 16'h1111);
    push_nd(2'd1, 2'd0, 16'h2222);
    chk_lk(2'd1, 2'd0, 1'b1, 16'h2222);
    chk_lk(2'd0, 2'd2, 1'b1, 16'h2222);
    chk_lk(2'd3, 2'd1, 1'b0, 16'h0000);
    fork
      push_nd(2'd2, 2'd3, 16'h7777);
      begin
        @(negedge clk); #1;
        chk("same_cycle_lk_hit", lk_hit, 0);
      end
    join
    chk_lk(2'd3, 2'd1, 1'b1, 16'h7777);
    chk_lk(2'd3, 2'd2, 1'b0, 16'h0000);
    drain_all();

    // Full with drain: pop only; next cycle push accepted.
    push_nd(2'd0, 2'd1, 16'h4001);
    push_nd(2'd0, 2'd2, 16'h4002);
    push_nd(2'd0, 2'd3, 16'h4003);
    push_nd(2'd1, 2'd1, 16'h4004);
    step(1'b1, 2'd2, 2'd3, 16'h5555, 1'b1, 1'b0);
    push_nd(2'd0, 2'd1, 16'h6666);
    step(1'b0, 2'd0, 2'd0, '0, 1'b0, 1'b0);
    drain_all();

    // Flush with simultaneous push and drain.
    push_nd(2'd0, 2'd1, 16'h0101);
    push_nd(2'd0, 2'd3, 16'h0303);
    push_nd(2'd2, 2'd0, 16'h2020);
    chk_lk(2'd0, 2'd1, 1'b1, 16'h0101);
    step(1'b1, 2'd1, 2'd1, 16'hBAD0, 1'b1, 1'b1);
    chk_lk(2'd0, 2'd1, 1'b0, 16'h0000);
    chk_lk(2'd1, 2'd1, 1'b0, 16'h0000);
    step(1'b0, 2'd0, 2'd0, '0, 1'b1, 1'b0);

    // Asynchronous reset mid-cycle with two entries queued.
    push_nd(2'd1, 2'd3, 16'hC001);
    push_nd(2'd2, 2'd2, 16'hC002);
    drain_en = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("async_count", count, 0);
    chk("async_rf_we", rf_we, 0);
    chk("async_rf_wdata", rf_wdata, 0);
    chk("async_wb_ready", wb_ready, 1);
    exp_q.delete();
    m_count = 0;
    @(negedge clk); @(negedge clk); #2;
    rst_n = 1'b1;
    wb_valid = 1'b1; wb_win = 2'd3; wb_reg = 2'd1; wb_data = 16'h0BEE;
    @(posedge clk); #1;
    wb_valid = 1'b0; drain_en = 1'b0;
    chk("first_edge_count", count, 1);
    m_count = 1;
    exp_q.push_back({2'd3, 2'd1, 16'h0BEE});
    for (int i = 0; i < 4; i++) step(1'b0, 2'd0, 2'd0, '0, 1'b1, 1'b0);

    // Random wrap-around passes.
    for (int p = 0; p < 10; p++) begin
      for (int i = 0; i < 6; i++) begin
        step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
             DW'($urandom_range(0, 16'hFFFF)), 1'($urandom_range(0, 1)), 1'b0);
      end
      drain_all();
    end

    chk("final_exp_q_empty", exp_q.size(), 0);
    chk("final_count", count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reg_writeback_queue.md
REG_WRITEBACK_QUEUE -- requirements
Module: reg_writeback_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of queued writeback entries (power of two, 2..8).
REQ-002 SHALL have parameter DW, default 16, data width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port wb_valid  input  1  writeback request present.
REQ-006 SHALL have port wb_ready  output  1  queue can accept a request this cycle.
REQ-007 SHALL have port wb_win  input  2  register window of request.
REQ-008 SHALL have port wb_reg  input  2  window-relative register of request.
REQ-009 SHALL have port wb_data  input  DW  write value.
REQ-010 SHALL have port drain_en  input  1  register-file write port granted this cycle.
REQ-011 SHALL have port flush  input  1  synchronous discard of all queued entries.
REQ-012 SHALL have port rf_we  output  1  write strobe to register file.
REQ-013 SHALL have ports rf_win  output  2, rf_reg  output  2, rf_wdata  output  DW  head-entry window, register, data.
REQ-014 SHALL have ports lk_win  input  2, lk_reg  input  2  forwarding lookup address.
REQ-015 SHALL have ports lk_hit  output  1, lk_data  output  DW  forwarding result.
REQ-016 SHALL have port count  output  clog2(DEPTH)+1  current occupancy.

Function
REQ-017 SHALL compute physical index as (2*win + reg) mod 8 for every entry and lookup (overlapping windows alias).
REQ-018 SHALL drive wb_ready = (count < DEPTH), independent of drain_en (no in-to-out combinational path).
REQ-019 SHALL enqueue at tail when wb_valid && wb_ready at rising edge; entries retain arrival order.
REQ-020 SHALL drive rf_we = (count != 0) && drain_en && !flush combinationally; rf_win/rf_reg/rf_wdata always show head entry (zero when empty).
REQ-021 SHALL dequeue head on the edge where rf_we is 1; register file captures the same edge.
REQ-022 SHALL give latency of one cycle: request accepted on edge N into empty queue appears on rf_* during cycle N+1.
REQ-023 SHALL, on simultaneous enqueue and dequeue, keep count unchanged and preserve order; full queue with drain accepts nothing new that cycle.
REQ-024 SHALL wrap head/tail pointers modulo DEPTH without loss or duplication.
REQ-025 SHALL assert lk_hit when any valid entry matches lookup physical index; lk_data SHALL be the newest (closest to tail) matching entry; lk_data zero when no hit.
REQ-026 SHALL include in lookup only entries resident at cycle start (same-cycle incoming wb_data not forwarded).
REQ-027 SHALL, on flush, empty queue at that edge, suppress rf_we that cycle, ignore any same-cycle enqueue.
REQ-028 SHALL ignore wb_valid when wb_ready is 0; wb_* need not be held.

Reset
REQ-029 SHALL, while rst_n low, force count=0, pointers=0, rf_we=0, lk_hit=0, wb_ready=1, rf_*/lk_data=0.
REQ-030 SHALL discard all queued entries on reset mid-operation; no rf_we issued for them after release.
REQ-031 SHALL accept first request on first rising edge after rst_n high.

Structure
REQ-032 SHALL place window count (4), physical register count (8), and phys-index function in shared package rf_pkg, reused by register file.
REQ-033 SHALL implement storage as one sub-module wbq_fifo (circular buffer, pointers, count); matching/priority logic stays in top.

Verification
REQ-034 SHALL test: empty, push win=1 reg=2 data=0x00AA, drain_en=1 -> next cycle rf_we=1, rf_win=1, rf_reg=2, rf_wdata=0x00AA, then count=0.
REQ-035 SHALL test: drain_en=0, push 4 entries -> count=4, wb_ready=0; 5th push ignored; drain 4 -> outputs in push order.
REQ-036 SHALL test: push (win=0,reg=2,0x1111) then (win=1,reg=0,0x2222); lookup win=1 reg=0 -> lk_hit=1, lk_data=0x2222 (alias phys 2, newest wins).
REQ-037 SHALL test: full queue, wb_valid=1 and drain_en=1 -> one pop, no push, count=3; next cycle push accepted, count=4.
REQ-038 SHALL test: 3 entries, flush=1 with wb_valid=1 -> rf_we=0, count=0 next cycle, lk_hit=0.
REQ-039 SHALL test: 2 entries, rst_n low asynchronously mid-cycle -> count=0, rf_we=0 immediately; after release no stale writes; 10 random wrap-around passes match scoreboard.
